// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
//   state_t  - receive FSM states
//   entry_t  - one FIFO entry: {ext, brk, code}
//   PS2_EXT / PS2_BRK - scan-code prefixes absorbed by the decoder
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } entry_t;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Valid/ready output stream of the PS/2 receiver.
//   m_valid - head entry present       (master -> slave)
//   m_data  - head scan code           (master -> slave)
//   m_ext   - head was preceded by E0  (master -> slave)
//   m_brk   - head was preceded by F0  (master -> slave)
//   m_ready - consumer takes the head  (slave -> master)
interface ps2_rx_fifo_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_ext;
  logic       m_brk;

  modport master (output m_valid, m_data, m_ext, m_brk, input m_ready);
  modport slave  (input m_valid, m_data, m_ext, m_brk, output m_ready);
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   wr_en/wr_data - push request; dropped (drop=1) when full and not popping
//   rd_en         - pop request; ignored when empty
//   rd_data       - head entry, zero while empty
//   count         - exact occupancy; full/empty flags
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_go, rd_go;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // When full, a simultaneous pop frees the slot being overwritten.
  assign wr_go = wr_en & (~full | rd_en);
  assign rd_go = rd_en & ~empty;
  assign drop  = wr_en & ~wr_go;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_go) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + 1'b1;
      if (rd_go) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, parity/stop checking,
// frame watchdog, optional E0/F0 prefix decoding and an FWFT output FIFO.
//   clk, reset        - system clock, async active-low reset
//   ps2clk, ps2data   - raw PS/2 lines
//   m                 - valid/ready output stream (master side)
//   fifo_level        - current FIFO occupancy
//   parity_err, frame_err, timeout_err, overflow - one-cycle error pulses
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int FIFO_DEPTH  = 8,
  parameter int DECODE      = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2clk,
  input  logic                            ps2data,
  ps2_rx_fifo_if.master                   m,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            timeout_err,
  output logic                            overflow
);
  localparam int  WDW = $clog2(TIMEOUT_CYC + 1);
  localparam bit  DEC = (DECODE != 0);
  localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  // Index 0 = clock line, index 1 = data line.
  logic [1:0] sync1, sync2, filt;
  logic [3:0] flt_cnt [2];
  logic       fall;

  // NOTE: non-blocking everywhere in clocked logic so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      sync2 <= '1;
      filt  <= '1;
      fall  <= 1'b0;
      for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
    end else begin
      sync1 <= {ps2data, ps2clk};
      sync2 <= sync1;
      // The filtered clock drops exactly when its filter accepts a 0.
      fall  <= filt[0] & ~sync2[0] & (flt_cnt[0] == FL_LAST);
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (flt_cnt[i] == FL_LAST) begin
            filt[i]    <= sync2[i];
            flt_cnt[i] <= '0;
          end else begin
            flt_cnt[i] <= flt_cnt[i] + 4'd1;
          end
        end else begin
          flt_cnt[i] <= '0;
        end
      end
    end
  end

  wire data_f = filt[1];

  state_t         state;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_acc;
  logic [WDW-1:0] wd;
  logic           ext_pend, brk_pend;
  logic           push;
  entry_t         push_entry;

  wire expire = (state != IDLE) && (wd == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_acc     <= 1'b0;
      wd          <= '0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      push        <= 1'b0;
      push_entry  <= '0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      push        <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;

      if (state == IDLE || fall) wd <= '0;
      else if (!expire)          wd <= wd + 1'b1;

      // A fall in the expiry cycle takes priority over the abort.
      if (fall) begin
        case (state)
          IDLE: if (!data_f) begin
            state   <= DATA;
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
          DATA: begin
            shreg   <= {data_f, shreg[7:1]};
            par_acc <= par_acc ^ data_f;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            if (par_acc ^ data_f) begin
              state <= STOP;
            end else begin
              state      <= IDLE;
              parity_err <= 1'b1;
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
            end
          end
          STOP: begin
            state <= IDLE;
            if (!data_f) begin
              frame_err <= 1'b1;
            end else if (DEC && shreg == PS2_EXT) begin
              ext_pend <= 1'b1;
            end else if (DEC && shreg == PS2_BRK) begin
              brk_pend <= 1'b1;
            end else begin
              push       <= 1'b1;
              push_entry <= '{ext: ext_pend, brk: brk_pend, code: shreg};
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (expire) begin
        state       <= IDLE;
        timeout_err <= 1'b1;
        ext_pend    <= 1'b0;
        brk_pend    <= 1'b0;
      end
    end
  end

  entry_t head;
  logic   full, empty;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (m.m_ready),
    .rd_data (head),
    .count   (fifo_level),
    .full    (full),
    .empty   (empty),
    .drop    (overflow)
  );

  assign m.m_valid = ~empty;
  assign m.m_data  = head.code;
  assign m.m_ext   = head.ext;
  assign m.m_brk   = head.brk;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
  localparam int FL    = 4;
  localparam int TO    = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ps2clk = 1'b1;
  logic ps2data = 1'b1;
  logic [LW-1:0] fifo_level;
  logic parity_err, frame_err, timeout_err, overflow;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH), .DECODE(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2clk      (ps2clk),
    .ps2data     (ps2data),
    .m           (bus),
    .fifo_level  (fifo_level),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference model: expected entries {ext, brk, code} and error counts.
  logic [9:0] exp_q[$];
  bit ext_m = 0, brk_m = 0;
  int exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovf = 0;
  int got_par = 0, got_frm = 0, got_to = 0, got_ovf = 0, n_pops = 0;

  function automatic void model_frame(logic [7:0] code, bit par_flip, bit stop);
    if (par_flip) begin
      exp_par++; ext_m = 0; brk_m = 0;
    end else if (!stop) begin
      exp_frm++;
    end else if (code == 8'hE0) begin
      ext_m = 1;
    end else if (code == 8'hF0) begin
      brk_m = 1;
    end else begin
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({ext_m, brk_m, code});
      ext_m = 0; brk_m = 0;
    end
  endfunction

  // Ready driver: directed value or random per cycle.
  bit rand_ready = 0;
  bit ready_cmd  = 1;
  always @(posedge clk) begin
    #1;
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
  end

  // Monitor: counts pulses and checks every popped entry against the model.
  always @(negedge clk) begin
    if (reset) begin
      if (parity_err)  got_par++;
      if (frame_err)   got_frm++;
      if (timeout_err) got_to++;
      if (overflow)    got_ovf++;
      if (bus.m_valid && bus.m_ready) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pop: got=%0h want=none", {bus.m_ext, bus.m_brk, bus.m_data});
        end else begin
          check("pop_entry", {22'd0, bus.m_ext, bus.m_brk, bus.m_data}, {22'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(bit b);
    ps2data = b;
    cyc(HALF);
    ps2clk = 1'b0;
    cyc(HALF);
    ps2clk = 1'b1;
  endtask

  task automatic send(logic [7:0] code, bit par_flip, bit stop);
    model_frame(code, par_flip, stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ par_flip);
    ps2_bit(stop);
    ps2data = 1'b1;
    cyc(HALF);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      cyc(1);
      n++;
    end
    cyc(2);
    check(name, exp_q.size(), 0);
    check({name, "_level"}, 32'(fifo_level), 0);
  endtask

  task automatic check_errs(string name);
    check({name, "_par"}, got_par, exp_par);
    check({name, "_frm"}, got_frm, exp_frm);
    check({name, "_to"},  got_to,  exp_to);
    check({name, "_ovf"}, got_ovf, exp_ovf);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got=running want=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int p0;
    #13;
    check("rst_valid", 32'(bus.m_valid), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_head",  {22'd0, bus.m_ext, bus.m_brk, bus.m_data}, 0);
    check("rst_errs",  {28'd0, parity_err, frame_err, timeout_err, overflow}, 0);
    cyc(3);
    reset = 1'b1;
    cyc(10);

    // Single good frame
    send(8'h1C, 0, 1);
    drain("basic");
    check("basic_pops", n_pops, 1);
    check_errs("basic");

    // Prefix packing, inspected at the head with the consumer stalled
    ready_cmd = 0;
    cyc(2);
    send(8'hE0, 0, 1);
    send(8'hF0, 0, 1);
    send(8'h74, 0, 1);
    check("pfx_level", 32'(fifo_level), 1);
    check("pfx_head", {22'd0, bus.m_ext, bus.m_brk, bus.m_data}, {22'd0, 2'b11, 8'h74});
    send(8'h1C, 0, 1);
    check("pfx_level2", 32'(fifo_level), 2);
    ready_cmd = 1;
    drain("pfx");

    // Parity error then recovery
    send(8'h1C, 1, 1);
    send(8'h32, 0, 1);
    drain("par");
    check_errs("par");

    // Stop-bit error keeps pending prefix
    send(8'hE0, 0, 1);
    send(8'h11, 0, 0);
    send(8'h6B, 0, 1);
    drain("frm");
    check_errs("frm");

    // Watchdog abort mid-frame, prefix discarded
    send(8'hF0, 0, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2data = 1'b1;
    exp_to++; ext_m = 0; brk_m = 0;
    cyc(TO + 10);
    check("to_pulse", got_to, exp_to);
    send(8'h2D, 0, 1);
    drain("to");

    // Overflow with stalled consumer
    ready_cmd = 0;
    cyc(2);
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 1);
    check("ovf_level", 32'(fifo_level), DEPTH);
    check("ovf_count", got_ovf, exp_ovf);
    check("ovf_head", 32'(bus.m_data), 32'h01);
    ready_cmd = 1;
    drain("ovf");

    // Randomised traffic with random back-pressure
    rand_ready = 1;
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [7:0] code;
      bit pf, st;
      r    = $urandom_range(0, 15);
      code = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      pf   = ($urandom_range(0, 7) == 0);
      st   = pf ? 1'b1 : ($urandom_range(0, 7) != 0);
      send(code, pf, st);
    end
    rand_ready = 0;
    ready_cmd  = 1;
    drain("rand");
    check_errs("rand");

    // Short glitch on the clock line while idle with data low
    p0 = n_pops;
    ps2data = 1'b0;
    cyc(10);
    ps2clk = 1'b0;
    cyc(2);
    ps2clk = 1'b1;
    cyc(TO + 20);
    ps2data = 1'b1;
    cyc(10);
    check("glitch_to", got_to, exp_to);
    check("glitch_pops", n_pops, p0);
    check("glitch_level", 32'(fifo_level), 0);

    // Reset in the middle of a frame with one entry buffered
    ready_cmd = 0;
    cyc(2);
    send(8'h1C, 0, 1);
    check("mid_level", 32'(fifo_level), 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2data = 1'b1;
    cyc(3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.m_valid), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_errs", {28'd0, parity_err, frame_err, timeout_err, overflow}, 0);
    exp_q.delete();
    ext_m = 0; brk_m = 0;
    cyc(5);
    reset = 1'b1;
    ready_cmd = 1;
    cyc(5);
    send(8'h1C, 0, 1);
    drain("post_rst");
    check_errs("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
